// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF) and data memory (DM).
// Data requests normally win. A starvation counter makes a waiting fetch win
// after STARVE_LIMIT consecutive data grants. The granted request is
// registered onto the mem_* port and held until mem_ack_i. The read data then
// comes back with a one-cycle ready pulse.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   if_req_i/if_addr_i    fetch request (held until if_ready_o)
//   if_rdata_o/if_ready_o fetched word + one-cycle completion pulse
//   if_stall_o            fetch stall for the hazard logic
//   dm_req_i/we/be/addr/wdata  data request (held until dm_ready_o)
//   dm_rdata_o/dm_ready_o load data + one-cycle completion pulse
//   dm_stall_o            data stall for the hazard logic
//   mem_req/we/be/addr/wdata_o  registered memory port, held until mem_ack_i
//   mem_rdata_i/mem_ack_i memory response
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ready_o,
  output logic                if_stall_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                dm_ready_o,
  output logic                dm_stall_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_DM, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    // Ready is a pulse: it only lives in the cycle after the ack.
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // DM wins unless IF has waited through STARVE_LIMIT data grants.
        if (dm_req_i && !(if_req_i && (starve_cnt_q == STARVE_MAX))) begin
          state_d     = GRANT_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_be_d    = dm_be_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (!if_req_i) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (if_req_i) begin
          state_d      = GRANT_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_be_d     = '1;
          mem_addr_d   = if_addr_i;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
        end
      end
      GRANT_IF: begin
        if (mem_ack_i) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata_i;
          if_ready_d = 1'b1;
        end
      end
      GRANT_DM: begin
        if (mem_ack_i) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          dm_rdata_d = mem_rdata_i;
          dm_ready_d = 1'b1;
        end
      end
      RESP: begin
        // The finished requester still shows req here, so skip arbitration.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ready_o  = if_ready_q;
  assign dm_ready_o  = dm_ready_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

  // Stalls drop in the same cycle as the ready pulse.
  assign if_stall_o  = if_req_i & ~if_ready_q;
  assign dm_stall_o  = dm_req_i & ~dm_ready_q;

endmodule
